// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit sampling FSM and a small
// receive FIFO popped through valid/ready, with sticky framing/overrun flags.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        rxd_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        busy_o,
    output logic                        framing_err_o,
    output logic                        overrun_o,
    input  logic                        clr_err_i
);

    localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic           sync1_q, sync2_q;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [PW:0]    wr_ptr_q, rd_ptr_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic           framing_q, overrun_q;

    logic           line_s, push_s, frame_err_s;
    logic [PW:0]    count_s;
    logic           valid_s, full_s, pop_s, push_ok_s, drop_s;

    assign line_s = sync2_q;

    // Line synchroniser and receiver state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            sync1_q   <= rxd_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Receiver next-state: timer restarts at every sample so each state entry begins at 0.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!line_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    if (line_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {line_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (line_s) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                timer_d = '0;
                if (line_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign valid_s   = (count_s != '0);
    assign full_s    = (count_s == (PW+1)'(FIFO_DEPTH));
    assign pop_s     = valid_s & ready_i;
    // A same-cycle pop frees the head slot, so a push into a full FIFO still fits.
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;

    // FIFO pointers and sticky error flags; a set event overrides a clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= push_ok_s ? (wr_ptr_q + (PW+1)'(1)) : wr_ptr_q;
            rd_ptr_q  <= pop_s ? (rd_ptr_q + (PW+1)'(1)) : rd_ptr_q;
            framing_q <= frame_err_s | (framing_q & ~clr_err_i);
            overrun_q <= drop_s | (overrun_q & ~clr_err_i);
        end
    end

    // FIFO storage; contents are only visible through a valid head, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= shift_q;
        end
    end

    assign data_o        = valid_s ? mem_q[rd_ptr_q[PW-1:0]] : 8'h00;
    assign valid_o       = valid_s;
    assign count_o       = count_s;
    assign busy_o        = (state_q != S_IDLE);
    assign framing_err_o = framing_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (16 clocks per bit, 4-entry FIFO); expected bytes
// are queued as frames are driven and compared as they are popped.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset, rxd, ready, clr;
    logic [7:0] data;
    logic       valid, busy, ferr, ovr;
    logic [2:0] count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset), .rxd_i(rxd), .data_o(data), .valid_o(valid),
        .ready_i(ready), .count_o(count), .busy_o(busy), .framing_err_o(ferr),
        .overrun_o(ovr), .clr_err_i(clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start + 8 data bits (144 clocks) and leaves the stop level on the line.
    task automatic frame_head(input logic [7:0] d, input logic stop_b);
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(16);
        end
        rxd = stop_b;
    endtask

    task automatic send(input logic [7:0] d);
        frame_head(d, 1'b1);
        tick(16);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " data"}, 32'(data), 32'(e));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxd = 1'b1; ready = 1'b0; clr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ferr", 32'(ferr), 32'd0);
        chk("rst ovr", 32'(ovr), 32'd0);

        // 0xA5: push lands exactly 155 clocks after the start edge is driven
        exp_q.push_back(8'hA5);
        frame_head(8'hA5, 1'b1);
        tick(10);
        chk("a5 busy", 32'(busy), 32'd1);
        chk("a5 valid early", 32'(valid), 32'd0);
        tick(1);
        chk("a5 valid", 32'(valid), 32'd1);
        chk("a5 data", 32'(data), 32'h0A5);
        chk("a5 count", 32'(count), 32'd1);
        chk("a5 ferr", 32'(ferr), 32'd0);
        chk("a5 ovr", 32'(ovr), 32'd0);
        tick(5);
        pop_chk("a5 pop");
        chk("a5 empty count", 32'(count), 32'd0);
        chk("a5 empty data", 32'(data), 32'd0);

        // Start glitch: 5 low clocks
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(5);
        chk("glitch busy", 32'(busy), 32'd1);
        tick(1);
        chk("glitch idle", 32'(busy), 32'd0);
        chk("glitch valid", 32'(valid), 32'd0);
        tick(4);

        // Framing error with line break, then a good frame
        frame_head(8'h3C, 1'b0);
        tick(40);
        chk("brk ferr", 32'(ferr), 32'd1);
        chk("brk count", 32'(count), 32'd0);
        chk("brk busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        tick(4);
        chk("brk idle", 32'(busy), 32'd0);
        exp_q.push_back(8'h55);
        send(8'h55);
        pop_chk("55 pop");
        chk("ferr sticky", 32'(ferr), 32'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ferr clr", 32'(ferr), 32'd0);

        // Overrun: fifth byte dropped
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send(8'(b));
        end
        chk("full count", 32'(count), 32'd4);
        chk("full no ovr", 32'(ovr), 32'd0);
        send(8'h05);
        chk("ovr count", 32'(count), 32'd4);
        chk("ovr set", 32'(ovr), 32'd1);
        for (int k = 0; k < 4; k++) pop_chk("ovr pop");
        chk("ovr empty", 32'(count), 32'd0);
        chk("ovr sticky", 32'(ovr), 32'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovr clr", 32'(ovr), 32'd0);

        // Full FIFO with a pop in the push cycle
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send(8'(b));
        end
        frame_head(8'h05, 1'b1);
        tick(10);
        chk("pp head", 32'(data), 32'(exp_q.pop_front()));
        exp_q.push_back(8'h05);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("pp count", 32'(count), 32'd4);
        chk("pp ovr", 32'(ovr), 32'd0);
        tick(5);
        for (int k = 0; k < 4; k++) pop_chk("pp pop");
        chk("pp empty", 32'(count), 32'd0);

        // Reset during data bit 4 of 0xFF, with a byte already buffered
        exp_q.push_back(8'h42);
        send(8'h42);
        chk("pre rst count", 32'(count), 32'd1);
        rxd = 1'b0;
        tick(16);
        rxd = 1'b1;
        tick(72);
        chk("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst count", 32'(count), 32'd0);
        chk("mrst valid", 32'(valid), 32'd0);
        chk("mrst data", 32'(data), 32'd0);
        chk("mrst ferr", 32'(ferr), 32'd0);
        chk("mrst ovr", 32'(ovr), 32'd0);
        tick(80);
        chk("mrst quiet", 32'(count), 32'd0);
        exp_q.push_back(8'h81);
        send(8'h81);
        chk("81 count", 32'(count), 32'd1);
        pop_chk("81 pop");
        chk("end count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
